etapa_fetch_pc: RTL and testbench

- Instruction-fetch front end of the RISC-V core. Holds the program counter and issues reads to the synchronous instruction memory.
- Buffers returned instructions in a 2-entry queue and hands {pc, instruccion} to decode over a valid/ready handshake.
- Drives the existing 32-bit adder (Sumador) with the current PC on input A; B is tied to 32'd4 at the top level.
- Consumes the adder's sum as the sequential next-PC and handles branch/jump redirects from execute.

---
 rtl/etapa_fetch_pc.sv | 91 +++++++++
 tb/tb_etapa_fetch_pc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/etapa_fetch_pc.sv
// Instruction-fetch front end: PC register, imem read issue,
// 2-entry return queue and valid/ready hand-off to decode.
module etapa_fetch_pc #(
  parameter int               ANCHO    = 32,
  parameter logic [ANCHO-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ANCHO-1:0] pc_o,
  input  logic [ANCHO-1:0] pc_mas4_i,
  output logic             imem_en_o,
  output logic [ANCHO-1:0] imem_addr_o,
  input  logic [ANCHO-1:0] imem_rdata_i,
  input  logic             salto_i,
  input  logic [ANCHO-1:0] salto_destino_i,
  output logic             valido_o,
  input  logic             listo_i,
  output logic [ANCHO-1:0] instr_o,
  output logic [ANCHO-1:0] instr_pc_o,
  output logic             error_alin_o
);

  logic [ANCHO-1:0] pc;
  logic [ANCHO-1:0] vuelo_pc;
  logic             vuelo;
  logic [1:0]       cuenta;
  logic             cab;
  logic             cola;
  logic [ANCHO-1:0] mem_pc  [2];
  logic [ANCHO-1:0] mem_ins [2];
  logic             err;
  logic             pop;
  logic             push;
  logic             issue;
  logic [2:0]       ocup;

  assign pop  = valido_o && listo_i;
  assign push = vuelo;
  assign cola = cab ^ cuenta[0];

  // Slot freed by this cycle's pop is reusable, so listo_i=1 sustains one per cycle.
  assign ocup  = {1'b0, cuenta} + {2'b00, vuelo} - {2'b00, pop};
  assign issue = !rst && !salto_i && (ocup < 3'd2);

  assign pc_o         = pc;
  assign imem_addr_o  = pc;
  assign imem_en_o    = issue;
  assign valido_o     = (cuenta != 2'd0);
  assign instr_o      = mem_ins[cab];
  assign instr_pc_o   = mem_pc[cab];
  assign error_alin_o = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= PC_RESET;
      vuelo_pc   <= '0;
      vuelo      <= 1'b0;
      cuenta     <= 2'd0;
      cab        <= 1'b0;
      err        <= 1'b0;
      mem_pc[0]  <= '0;
      mem_pc[1]  <= '0;
      mem_ins[0] <= '0;
      mem_ins[1] <= '0;
    end else begin
      err   <= salto_i && (salto_destino_i[1:0] != 2'b00);
      vuelo <= issue;
      if (issue) begin
        pc       <= pc_mas4_i;
        vuelo_pc <= pc;
      end
      // Redirect drops the queue and the returning in-flight word.
      if (salto_i) begin
        pc     <= {salto_destino_i[ANCHO-1:2], 2'b00};
        cuenta <= 2'd0;
      end else begin
        if (push) begin
          mem_pc[cola]  <= vuelo_pc;
          mem_ins[cola] <= imem_rdata_i;
        end
        if (pop) cab <= ~cab;
        unique case ({push, pop})
          2'b10:   cuenta <= cuenta + 2'd1;
          2'b01:   cuenta <= cuenta - 2'd1;
          default: cuenta <= cuenta;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_etapa_fetch_pc.sv
// Randomized scoreboard bench for etapa_fetch_pc, plus a second
// instance with PC_RESET near the top of the address space.
module tb_etapa_fetch_pc;

  localparam logic [31:0] K   = 32'hA5A5_A5A5;
  localparam logic [31:0] PCR = 32'h0000_0000;
  localparam logic [31:0] PCW = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_o, pc_mas4, imem_addr, imem_rdata, dest, instr, instr_pc;
  logic        imem_en, salto, valido, listo, err;

  logic [31:0] pc_w, addr_w, rdata_w, instr_w, ipc_w;
  logic        en_w, valido_w, err_w;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  always #5 clk = ~clk;

  assign pc_mas4 = pc_o + 32'd4;

  etapa_fetch_pc #(.ANCHO(32), .PC_RESET(PCR)) dut (
    .clk(clk), .rst(rst), .pc_o(pc_o), .pc_mas4_i(pc_mas4),
    .imem_en_o(imem_en), .imem_addr_o(imem_addr),
    .imem_rdata_i(imem_rdata), .salto_i(salto),
    .salto_destino_i(dest), .valido_o(valido), .listo_i(listo),
    .instr_o(instr), .instr_pc_o(instr_pc), .error_alin_o(err)
  );

  etapa_fetch_pc #(.ANCHO(32), .PC_RESET(PCW)) u_w (
    .clk(clk), .rst(rst), .pc_o(pc_w), .pc_mas4_i(pc_w + 32'd4),
    .imem_en_o(en_w), .imem_addr_o(addr_w),
    .imem_rdata_i(rdata_w), .salto_i(1'b0),
    .salto_destino_i(32'd0), .valido_o(valido_w), .listo_i(1'b1),
    .instr_o(instr_w), .instr_pc_o(ipc_w), .error_alin_o(err_w)
  );

  // Synchronous instruction memory: word = address ^ K
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ K;
    if (en_w)    rdata_w    <= addr_w ^ K;
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  // Scoreboard / reference model: delivered stream is target, +4, +8...
  logic [31:0] exp_q[$];
  logic [31:0] gen, e;
  logic        err_exp, hold;
  int          outst;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      gen     = PCR;
      err_exp = 1'b0;
      hold    = 1'b0;
      outst   = 0;
    end else begin
      chk("error_alin", {31'd0, err}, {31'd0, err_exp});
      if (hold) chk("hold_valido", {31'd0, valido}, 32'd1);
      if (imem_en)
        chk("overflow", ((outst - int'(valido && listo)) < 2) ? 32'd1 : 32'd0, 32'd1);
      if (salto) chk("no_issue_on_salto", {31'd0, imem_en}, 32'd0);
      if (valido && listo) begin
        while (exp_q.size() < 3) begin
          exp_q.push_back(gen);
          gen = gen + 32'd4;
        end
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, e ^ K);
        pops++;
      end
      outst   = outst + int'(imem_en) - int'(valido && listo);
      hold    = valido && !listo && !salto;
      err_exp = salto && (dest[1:0] != 2'b00);
      if (salto) begin
        exp_q.delete();
        gen   = {dest[31:2], 2'b00};
        outst = 0;
      end
    end
  end

  // Wrap-around instance: continuous consumption from PC_RESET
  logic [31:0] gen_w;
  always @(negedge clk) begin
    if (rst) begin
      gen_w = PCW;
      chk("w_reset_pc", pc_w, PCW);
    end else if (valido_w) begin
      chk("w_pc", ipc_w, gen_w);
      chk("w_instr", instr_w, gen_w ^ K);
      gen_w = gen_w + 32'd4;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_en;
  logic prev_salto;

  initial begin
    rst = 1'b1; listo = 1'b1; salto = 1'b0; dest = '0;
    repeat (2) step();
    chk("rst_valido", {31'd0, valido}, 32'd0);
    chk("rst_en", {31'd0, imem_en}, 32'd0);
    chk("rst_pc", pc_o, PCR);
    rst = 1'b0;

    // Latency: issues 0,4,8,12 back to back, valido from cycle 2
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lat_en", {31'd0, imem_en}, 32'd1);
      chk("lat_addr", imem_addr, 32'(4 * i));
      chk("lat_valido", {31'd0, valido}, (i >= 2) ? 32'd1 : 32'd0);
    end
    step();

    // Backpressure from cycle 0
    rst = 1'b1; step(); listo = 1'b0; rst = 1'b0;
    n_en = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_en) begin
        chk("bp_addr", imem_addr, 32'(4 * n_en));
        n_en++;
      end
    end
    chk("bp_count", 32'(n_en), 32'd2);
    chk("bp_pc", instr_pc, 32'd0);
    step();
    listo = 1'b1;
    repeat (6) step();

    // Redirect while streaming
    salto = 1'b1; dest = 32'h0000_0100;
    step();
    salto = 1'b0;
    @(negedge clk);
    chk("redir_valido", {31'd0, valido}, 32'd0);
    chk("redir_en", {31'd0, imem_en}, 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    repeat (5) step();

    // Misaligned target
    salto = 1'b1; dest = 32'h0000_0102;
    step();
    salto = 1'b0;
    @(negedge clk);
    chk("alin_hi", {31'd0, err}, 32'd1);
    chk("alin_addr", imem_addr, 32'h0000_0100);
    @(negedge clk);
    chk("alin_lo", {31'd0, err}, 32'd0);
    step();

    // Wrap through the adder
    salto = 1'b1; dest = 32'hFFFF_FFF8;
    step();
    salto = 1'b0;
    repeat (8) step();

    // Random traffic
    prev_salto = 1'b0;
    for (int i = 0; i < 600; i++) begin
      listo = ($urandom_range(0, 9) < 7);
      salto = !prev_salto && ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0:       dest = $urandom;
        1:       dest = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: dest = 32'($urandom_range(0, 255));
      endcase
      prev_salto = salto;
      step();
    end
    salto = 1'b0;
    listo = 1'b1;
    repeat (4) step();

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_pc", pc_o, PCR);
    chk("arst_en", {31'd0, imem_en}, 32'd0);
    chk("arst_valido", {31'd0, valido}, 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_ipc", instr_pc, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #4 rst = 1'b0;
    @(negedge clk);
    chk("restart_en", {31'd0, imem_en}, 32'd1);
    chk("restart_addr", imem_addr, PCR);
    repeat (20) step();

    chk("throughput", (pops > 100) ? 32'd1 : 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
